// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_mux
//  Purpose  : Time-multiplexed 7-segment display driver. Scans PAIRS two-digit
//             segment words onto one shared, active-low segment bus. Each digit
//             gets one slot that starts with a blanking gap. Fields selected by
//             blink_mask are blanked on alternate blink half-periods.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1         system clock, rising edge
//    reset        in   1         asynchronous, active-low reset
//    enable       in   1         1 = scan, 0 = display dark
//    digits_7seg  in   14*PAIRS  field p at [14p+13:14p]; digit k at [7k+6:7k]
//                                (digit 2p = ones, 2p+1 = tens of field p)
//    blink_mask   in   PAIRS     bit p = 1 blinks field p
//    seg          out  7         segment bus, active-low (7'h7F = dark)
//    dig_sel      out  2*PAIRS   digit select, active-low one-hot
//    frame_tick   out  1         pulse on the last clock of each full frame
// ============================================================================
module seg7_scan_mux #(
   parameter int PAIRS        = 3,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [14*PAIRS-1:0]  digits_7seg,
   input  logic [PAIRS-1:0]     blink_mask,
   output logic [6:0]           seg,
   output logic [2*PAIRS-1:0]   dig_sel,
   output logic                 frame_tick
);

   localparam int NDIG = 2 * PAIRS;
   localparam int CW   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int KW   = (NDIG > 1)         ? $clog2(NDIG)         : 1;
   localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0]   CNT_LAST   = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0]   BLANK_END  = CW'(BLANK_CYCLES);
   localparam logic [KW-1:0]   K_LAST     = KW'(NDIG - 1);
   localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [NDIG-1:0] SEL_ONE    = NDIG'(1);
   localparam logic [6:0]      SEG_DARK   = 7'h7F;

   // IDLE covers both post-reset and enable=0: the first enabled edge out of
   // IDLE lands on slot 0, cnt 0, so a restart always begins with a blank gap.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t              state, state_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic [KW-1:0]       k, k_nx;
   logic [FW-1:0]       frame, frame_nx;
   logic                blink, blink_nx;
   logic [6:0]          pat, pat_nx;

   logic [6:0]          seg_nx;
   logic [NDIG-1:0]     sel_nx;
   logic                tick_nx;

   logic [6:0]          cur_digit;
   logic                cur_mask;
   logic                in_blank;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         k          <= '0;
         frame      <= '0;
         blink      <= 1'b0;
         pat        <= SEG_DARK;
         seg        <= SEG_DARK;
         dig_sel    <= '1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         k          <= k_nx;
         frame      <= frame_nx;
         blink      <= blink_nx;
         pat        <= pat_nx;
         seg        <= seg_nx;
         dig_sel    <= sel_nx;
         frame_tick <= tick_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state: slot counter, digit index, frame counter, blink phase.
   // The frame counter and blink phase are left alone while disabled.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      k_nx     = k;
      frame_nx = frame;
      blink_nx = blink;

      if (!enable) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
         k_nx     = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx = ST_SCAN;
               cnt_nx   = '0;
               k_nx     = '0;
            end
            ST_SCAN: begin
               if (cnt == CNT_LAST) begin
                  cnt_nx = '0;
                  if (k == K_LAST) begin
                     k_nx = '0;
                     if (frame == FRAME_LAST) begin
                        frame_nx = '0;
                        blink_nx = ~blink;
                     end else begin
                        frame_nx = frame + 1'b1;
                     end
                  end else begin
                     k_nx = k + 1'b1;
                  end
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
               k_nx     = '0;
            end
         endcase
      end
   end

   // Blank phase of the upcoming cycle. With no blank gap the comparison would
   // be against zero, so it is dropped entirely.
   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (cnt_nx < BLANK_END);
      end
   endgenerate

   // Pattern and blink-mask bit of the digit the next cycle will show.
   always_comb begin
      cur_digit = SEG_DARK;
      cur_mask  = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (k_nx == KW'(i)) begin
            cur_digit = digits_7seg[7*i +: 7];
            cur_mask  = blink_mask[i/2];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs are computed from the next state and registered with it, so no
   // input reaches a pin without passing through a flop. The pattern is
   // latched on the edge entering the active phase and shown on that same
   // edge. Later input changes wait for the next slot.
   // ------------------------------------------------------------------------
   always_comb begin
      pat_nx  = pat;
      seg_nx  = SEG_DARK;
      sel_nx  = '1;
      tick_nx = 1'b0;

      if (enable) begin
         tick_nx = (k_nx == K_LAST) && (cnt_nx == CNT_LAST);
         if (cnt_nx == BLANK_END) begin
            pat_nx = cur_digit;
         end
         if (!in_blank) begin
            sel_nx = ~(SEL_ONE << k_nx);
            // A blinked digit keeps its select asserted and only darkens seg.
            seg_nx = (blink_nx && cur_mask) ? SEG_DARK : pat_nx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_mux
//  Purpose  : Directed self-checking bench for seg7_scan_mux with PAIRS=3,
//             DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux;

   localparam int PAIRS = 3;
   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int BF    = 2;
   localparam int FRAME = 2 * PAIRS * DC;   // 48 clocks

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                enable = 1'b1;
   logic [14*PAIRS-1:0] digits_7seg = '0;
   logic [PAIRS-1:0]    blink_mask = '0;
   logic [6:0]          seg;
   logic [2*PAIRS-1:0]  dig_sel;
   logic                frame_tick;

   int total = 0;
   int bad   = 0;

   logic [6:0] dexp [6];
   logic [2:0] mask_v;

   seg7_scan_mux #(
      .PAIRS        (PAIRS),
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC),
      .BLINK_FRAMES (BF)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .digits_7seg (digits_7seg),
      .blink_mask  (blink_mask),
      .seg         (seg),
      .dig_sel     (dig_sel),
      .frame_tick  (frame_tick)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_dark(input string tag);
      check({tag, " seg"},  {25'd0, seg},     32'h7F);
      check({tag, " sel"},  {26'd0, dig_sel}, 32'h3F);
      check({tag, " tick"}, {31'd0, frame_tick}, 32'h0);
   endtask

   // Hand-derived rule for one cycle at position pos within a frame.
   task automatic check_cycle(input int pos, input bit blk, input string tag);
      int         kk;
      int         cc;
      logic [6:0] es;
      logic [5:0] ed;
      logic       et;
      kk = pos / DC;
      cc = pos % DC;
      if (cc < BC) begin
         es = 7'h7F;
         ed = 6'h3F;
      end else begin
         ed = ~(6'b000001 << kk);
         es = (blk && mask_v[kk/2]) ? 7'h7F : dexp[kk];
      end
      et = (pos == FRAME - 1);
      check($sformatf("%s p%0d seg", tag, pos),  {25'd0, seg},        {25'd0, es});
      check($sformatf("%s p%0d sel", tag, pos),  {26'd0, dig_sel},    {26'd0, ed});
      check($sformatf("%s p%0d tick", tag, pos), {31'd0, frame_tick}, {31'd0, et});
   endtask

   initial begin
      dexp[0] = 7'h40; dexp[1] = 7'h79; dexp[2] = 7'h24;
      dexp[3] = 7'h30; dexp[4] = 7'h19; dexp[5] = 7'h12;
      mask_v  = 3'b010;

      // Reset with arbitrary inputs
      digits_7seg = 42'h2A5_5A5A_C3C3;
      blink_mask  = 3'b111;
      #1 reset = 1'b0;
      #1 check_dark("reset async");
      repeat (3) step();
      check_dark("reset held");

      for (int i = 0; i < 6; i++) digits_7seg[7*i +: 7] = dexp[i];
      blink_mask = mask_v;
      @(negedge clock);
      reset = 1'b1;

      // Scan order, mid-slot change, blink over frames 0..6
      for (int c = 0; c <= 6*FRAME + 20; c++) begin
         step();
         check_cycle(c % FRAME, ((c / FRAME) / BF) % 2 == 1, "scan");
         if (c == 4) digits_7seg[6:0] = 7'h79;
         if (c == DC - 1) dexp[0] = 7'h79;
      end

      // Enable drop during digit 2 active phase, blink phase 1
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_dark("disabled");
      end
      enable = 1'b1;

      // Restart: blink phase and frame counter held, so 2 blinked frames follow
      for (int r = 0; r <= 3*FRAME + 27; r++) begin
         step();
         check_cycle(r % FRAME, ((r / FRAME) / BF) % 2 == 0, "restart");
      end

      // Asynchronous reset between edges while digit 3 is active
      #1 reset = 1'b0;
      #1 check_dark("midscan reset");
      repeat (2) step();
      check_dark("midscan held");
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         check_cycle(c, 1'b0, "rerun");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed 7-segment display driver for the calendar/clock datapath. It accepts the per-field 14-bit two-digit segment words that the time-field counters produce (ones digit in bits [6:0], tens digit in bits [13:7]). It scans them one digit at a time onto a shared segment bus with one-hot digit selects, inserting a blanking gap between digits. In set mode it blinks the fields that are being edited. It sits between the field counters and the board's shared-segment display.

## Interface

Parameters:
- PAIRS, 3, number of two-digit fields (e.g. hour, minute, second); 2*PAIRS digits total
- DIGIT_CYCLES, 50000, clocks per digit slot; must be ≥ 2
- BLANK_CYCLES, 500, blanked clocks at the start of each slot; 0 ≤ BLANK_CYCLES < DIGIT_CYCLES
- BLINK_FRAMES, 64, full scan frames per blink half-period; must be ≥ 1

Ports:
- clock  in  1  system clock; one clock domain, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = scan, 0 = display dark
- digits_7seg  in  14*PAIRS  field p occupies [14p+13:14p]; digit k = bits [7k+6:7k]; digit 2p = ones, 2p+1 = tens
- blink_mask  in  PAIRS  bit p = 1 blinks field p (driven from set-mode selection)
- seg  out  7  segment bus, active-low; all-ones = dark
- dig_sel  out  2*PAIRS  digit select, active-low one-hot; all-ones = none
- frame_tick  out  1  one-cycle pulse on the last clock of each full frame

## Operation

- State: slot counter cnt (0..DIGIT_CYCLES-1), digit index k (0..2*PAIRS-1), frame counter (0..BLINK_FRAMES-1), blink phase bit, and a captured pattern register.
- Each clock with enable=1, cnt increments. When cnt wraps from DIGIT_CYCLES-1 to 0, k advances. When k wraps from 2*PAIRS-1 to 0, the frame counter increments.
- When the frame counter wraps from BLINK_FRAMES-1 to 0, the blink phase toggles.
- Blank phase (cnt < BLANK_CYCLES): seg = 7'h7F, dig_sel = all ones.
- Active phase (cnt ≥ BLANK_CYCLES): dig_sel = ~(1<<k).
  - seg = captured pattern of digit k.
  - If the blink phase is 1 and blink_mask[k/2] = 1, seg = 7'h7F while dig_sel stays asserted.
- Capture: digit k's pattern is latched on the edge that enters the active phase. Input changes later in the slot are ignored until the next slot.
- frame_tick = 1 exactly in the cycle with k = 2*PAIRS-1 and cnt = DIGIT_CYCLES-1, with enable=1.
- enable=0:
  - On the next edge: seg = 7F, dig_sel = all ones, frame_tick = 0.
  - cnt and k are forced to 0.
  - The frame counter and blink phase hold.
  - When enable returns to 1, scanning restarts at digit 0 with cnt = 0 (blank phase).
- blink_mask is sampled every cycle; a change takes effect at the next active-phase cycle.
- Reset (reset=0, asynchronous, no clock needed):
  - seg = 7F, dig_sel = all ones, frame_tick = 0.
  - cnt, k, frame counter and blink phase = 0.
  - Pattern register = 7F.
  - Scanning starts from digit 0, blank phase, on the first edge after release.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- For each slot, counting the first cycle of the slot as cnt = 0:
  - Blank for cycles 0..BLANK_CYCLES-1.
  - Active for cycles BLANK_CYCLES..DIGIT_CYCLES-1.
- Frame length = 2*PAIRS*DIGIT_CYCLES clocks. Blink half-period = BLINK_FRAMES frames.
- With BLANK_CYCLES = 0: there is no blank phase, and capture occurs on the edge that enters cnt = 0.
- At a slot boundary, dig_sel never shows two digits active, including the BLANK_CYCLES = 0 case.

## Test plan

All scenarios use PAIRS=3, DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2. Cycles are counted from the first edge after reset release.

1. **Reset.** Hold reset=0 with arbitrary inputs. Required: seg = 7F, dig_sel = 6'h3F, frame_tick = 0. After release, cycles 0–1 stay dark; cycle 2 shows digit 0.
2. **Scan order.** Drive digits 0..5 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12. Required for each k:
   - Cycles 8k+2..8k+7: dig_sel = ~(1<<k) and the matching seg.
   - Cycles 8k, 8k+1: dark.
   - frame_tick high only at cycle 47; digit 0 reappears at cycle 50.
3. **Mid-slot change.** Change digit 0 from 7'h40 to 7'h79 at cycle 4. Required: seg stays 7'h40 through cycle 7; 7'h79 appears at cycle 50.
4. **Blink.** blink_mask = 3'b010. Required:
   - Frames 0–1 and 4–5: all digits shown.
   - Frames 2–3: digits 2 and 3 have dig_sel asserted with seg = 7F.
   - Fields 0 and 2 are unaffected throughout.
5. **Enable drop.** Deassert enable at cycle 20 (digit 2 active). Required:
   - Dark from cycle 21.
   - On reassertion: 2 dark cycles, then digit 0.
   - Blink phase is preserved across the drop.
6. **Async reset mid-scan.** Pull reset=0 between edges during digit 3's active phase. Required: seg = 7F and dig_sel = 3F immediately, without a clock edge; restart follows scenario 1.
